// File: rtl/perceptron_train_seq.sv
// Training sequencer for the perceptron datapath: walks epochs and samples,
// issues weight/error control strobes and reports convergence.
// Build option: define PERC_EARLY_STOP_EN to stop at the first error-free
// epoch; otherwise every run lasts MAX_EPOCHS epochs.
module perceptron_train_seq #(
  parameter int unsigned N_SAMPLES  = 4,
  parameter int unsigned SAMPLE_W   = 2,
  parameter int unsigned MAX_EPOCHS = 10,
  parameter int unsigned EPOCH_W    = 4,
  parameter int unsigned FWD_LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                err_nz,
  output logic                clr_w,
  output logic                clr_e,
  output logic                ld_e,
  output logic                ld_w,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic [EPOCH_W-1:0]  epoch_idx,
  output logic                busy,
  output logic                done,
  output logic                converged
);

  localparam int unsigned FWD_W = (FWD_LAT > 1) ? $clog2(FWD_LAT) : 1;
  localparam logic [FWD_W-1:0]    FWD_LAST    = FWD_W'(FWD_LAT - 1);
  localparam logic [SAMPLE_W-1:0] LAST_SAMPLE = SAMPLE_W'(N_SAMPLES - 1);
  localparam logic [EPOCH_W-1:0]  LAST_EPOCH  = EPOCH_W'(MAX_EPOCHS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    EPOCH = 3'd2,
    FWD   = 3'd3,
    BACK  = 3'd4,
    CHECK = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [FWD_W-1:0]  fwd_cnt;
  logic [FWD_W-1:0]  fwd_nxt;
  logic              err_flag;

  logic clr_w_nxt;
  logic clr_e_nxt;
  logic ld_e_nxt;
  logic ld_w_nxt;
  logic busy_nxt;
  logic done_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and forward-latency counter update
  always_comb begin
    next_state = state;
    fwd_nxt    = '0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = INIT;
        end
      end
      INIT:  next_state = EPOCH;
      EPOCH: next_state = FWD;
      FWD: begin
        if (fwd_cnt == FWD_LAST) begin
          next_state = BACK;
        end else begin
          fwd_nxt = fwd_cnt + FWD_W'(1);
        end
      end
      BACK: begin
        if (sample_idx == LAST_SAMPLE) begin
          next_state = CHECK;
        end else begin
          next_state = FWD;
        end
      end
      CHECK: begin
`ifdef PERC_EARLY_STOP_EN
        if (!err_flag || (epoch_idx == LAST_EPOCH)) begin
          next_state = DONE;
        end else begin
          next_state = EPOCH;
        end
`else
        if (epoch_idx == LAST_EPOCH) begin
          next_state = DONE;
        end else begin
          next_state = EPOCH;
        end
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore decode of the upcoming state, so the strobes are registered
  always_comb begin
    clr_w_nxt = 1'b0;
    clr_e_nxt = 1'b0;
    ld_e_nxt  = 1'b0;
    ld_w_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (next_state)
      INIT: begin
        clr_w_nxt = 1'b1;
        clr_e_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      EPOCH: busy_nxt = 1'b1;
      FWD: begin
        ld_e_nxt = (fwd_nxt == FWD_LAST);
        busy_nxt = 1'b1;
      end
      BACK: begin
        ld_w_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      CHECK: busy_nxt = 1'b1;
      DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  // Control output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_w <= 1'b0;
      clr_e <= 1'b0;
      ld_e  <= 1'b0;
      ld_w  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      clr_w <= clr_w_nxt;
      clr_e <= clr_e_nxt;
      ld_e  <= ld_e_nxt;
      ld_w  <= ld_w_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Sample/epoch counters, epoch error flag and convergence status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_idx <= '0;
      epoch_idx  <= '0;
      converged  <= 1'b0;
      fwd_cnt    <= '0;
      err_flag   <= 1'b0;
    end else begin
      fwd_cnt <= fwd_nxt;
      case (state)
        INIT: begin
          epoch_idx <= '0;
          converged <= 1'b0;
        end
        EPOCH: begin
          sample_idx <= '0;
          err_flag   <= 1'b0;
        end
        BACK: begin
          err_flag <= err_flag | err_nz;
          if (sample_idx != LAST_SAMPLE) begin
            sample_idx <= sample_idx + SAMPLE_W'(1);
          end
        end
        CHECK: begin
`ifdef PERC_EARLY_STOP_EN
          if (!err_flag) begin
            converged <= 1'b1;
          end else if (epoch_idx == LAST_EPOCH) begin
            converged <= 1'b0;
          end else begin
            epoch_idx <= epoch_idx + EPOCH_W'(1);
          end
`else
          if (epoch_idx == LAST_EPOCH) begin
            converged <= !err_flag;
          end else begin
            epoch_idx <= epoch_idx + EPOCH_W'(1);
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_seq.sv
// Scoreboard bench for perceptron_train_seq: each launched run pushes its
// expected outcome; a monitor checks strobes per cycle and pops at done.
module tb_perceptron_train_seq;

  localparam int unsigned N_SAMPLES  = 4;
  localparam int unsigned SAMPLE_W   = 2;
  localparam int unsigned MAX_EPOCHS = 10;
  localparam int unsigned EPOCH_W    = 4;
  localparam int unsigned FWD_LAT    = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                err_nz = 1'b0;
  logic                clr_w;
  logic                clr_e;
  logic                ld_e;
  logic                ld_w;
  logic [SAMPLE_W-1:0] sample_idx;
  logic [EPOCH_W-1:0]  epoch_idx;
  logic                busy;
  logic                done;
  logic                converged;

  typedef struct {
    int cycles;
    int ldw;
    int conv;
    int epoch;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int total = 0;
  int bad = 0;
  int err_mode = 0;

  // Monitor state
  bit in_run = 0;
  int cyc = 0;
  int ldw_cnt = 0;
  int idle_cnt = 0;
  int run_gap = 0;
  bit prev_ld_e = 0;

  perceptron_train_seq #(
    .N_SAMPLES (N_SAMPLES),
    .SAMPLE_W  (SAMPLE_W),
    .MAX_EPOCHS(MAX_EPOCHS),
    .EPOCH_W   (EPOCH_W),
    .FWD_LAT   (FWD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .err_nz    (err_nz),
    .clr_w     (clr_w),
    .clr_e     (clr_e),
    .ld_e      (ld_e),
    .ld_w      (ld_w),
    .sample_idx(sample_idx),
    .epoch_idx (epoch_idx),
    .busy      (busy),
    .done      (done),
    .converged (converged)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic push(input int c, input int l, input int cv, input int ep, input int g);
    exp_t x;
    x.cycles = c;
    x.ldw    = l;
    x.conv   = cv;
    x.epoch  = ep;
    x.gap    = g;
    exp_q.push_back(x);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL run_timeout: %0d runs still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Error pattern driven to the datapath input, per mode
  always @(negedge clk) begin
    case (err_mode)
      0:       err_nz = 1'b0;
      1:       err_nz = 1'b1;
      default: err_nz = (int'(epoch_idx) < 3);
    endcase
  end

  // Monitor: per-cycle strobe checks and run-end scoreboard compare
  always @(negedge clk) begin
    if (rst) begin
      in_run    = 0;
      idle_cnt  = 0;
      prev_ld_e = 0;
    end else begin
      if (busy && !in_run) begin
        in_run   = 1;
        cyc      = 1;
        ldw_cnt  = 0;
        run_gap  = idle_cnt;
        idle_cnt = 0;
        chk("clr_on_init", int'({clr_w, clr_e}), 3);
      end else if (busy) begin
        cyc++;
        if (cyc == 2) begin
          chk("init_clears_converged", int'(converged), 0);
          chk("init_clears_epoch", int'(epoch_idx), 0);
        end
      end else begin
        idle_cnt++;
      end
      if (ld_w) begin
        chk("ld_e_before_ld_w", int'(prev_ld_e), 1);
        chk("sample_idx_on_ld_w", int'(sample_idx), ldw_cnt % N_SAMPLES);
        ldw_cnt++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: done pulse with no run pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cycles);
          chk("ld_w_count", ldw_cnt, e.ldw);
          chk("converged", int'(converged), e.conv);
          chk("epoch_idx_at_done", int'(epoch_idx), e.epoch);
          if (e.gap >= 0) chk("restart_gap", run_gap, e.gap);
        end
        in_run = 0;
      end
      prev_ld_e = ld_e;
    end
  end

  // Global guard so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({clr_w, clr_e, ld_e, ld_w, busy, done, converged, sample_idx, epoch_idx}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);

    // Run 1: no errors ever
    err_mode = 0;
`ifdef PERC_EARLY_STOP_EN
    push(12, 4, 1, 0, -1);
`else
    push(102, 40, 1, 9, -1);
`endif
    pulse_start();
    wait_done(300);
    @(negedge clk);
    chk("converged_held_run1", int'(converged), 1);

    // Run 2: errors in every epoch
    err_mode = 1;
    push(102, 40, 0, 9, -1);
    pulse_start();
    wait_done(300);
    @(negedge clk);
    chk("converged_held_run2", int'(converged), 0);
    chk("epoch_held_run2", int'(epoch_idx), 9);

    // Run 3: errors in epochs 0-2 only
    err_mode = 2;
`ifdef PERC_EARLY_STOP_EN
    push(42, 16, 1, 3, -1);
`else
    push(102, 40, 1, 9, -1);
`endif
    pulse_start();
    wait_done(300);
    @(negedge clk);
    chk("converged_held_run3", int'(converged), 1);

    // Run 4/5: start held high through a run, back-to-back restart
    err_mode = 0;
`ifdef PERC_EARLY_STOP_EN
    push(12, 4, 1, 0, -1);
    push(12, 4, 1, 0, 1);
`else
    push(102, 40, 1, 9, -1);
    push(102, 40, 1, 9, 1);
`endif
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (exp_q.size() > 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(300);

    // Reset during FWD of sample 1
    err_mode = 1;
    pulse_start();
    found = 0;
    n = 0;
    while (!found && n < 50) begin
      @(negedge clk);
      if (ld_e && sample_idx == SAMPLE_W'(1)) found = 1;
      n++;
    end
    chk("reach_fwd_sample1", int'(found), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({clr_w, clr_e, ld_e, ld_w, busy, done, converged, sample_idx, epoch_idx}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_mid_reset", int'(busy), 0);

    // Recovery run after the mid-run reset
    err_mode = 0;
`ifdef PERC_EARLY_STOP_EN
    push(12, 4, 1, 0, -1);
`else
    push(102, 40, 1, 9, -1);
`endif
    pulse_start();
    wait_done(300);
    repeat (3) @(negedge clk);
    chk("final_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
